// File: rtl/ncl_addn_clk.sv
// ncl_addn_clk: clocked dual-rail (NCL-style) adder/subtractor.
//   Captures a complete DATA wavefront on a_dr/b_dr/cin_dr/sub_dr, resolves
//   DPC digits per clock (LSB group first), then presents a dual-rail result
//   until downstream acknowledges, then returns to NULL.
// Ports:
//   clk      - rising-edge clock
//   initN    - asynchronous active-low reset
//   a_dr     - operand A, digit i on bits {2i+1,2i}
//   b_dr     - operand B, same packing
//   cin_dr   - carry-in digit
//   sub_dr   - mode digit (DATA1 = subtract, DATA0 = add)
//   in_ack   - 1 = input DATA captured, request NULL
//   sum_dr   - dual-rail sum (all-NULL unless result is held)
//   cout_dr  - dual-rail carry-out
//   out_ack  - downstream completion (1 = DATA accepted, request NULL)
//   err      - sticky flag: illegal 11 code seen on inputs while idle
module ncl_addn_clk #(
  parameter int W   = 8,
  parameter int DPC = 4
) (
  input  logic           clk,
  input  logic           initN,
  input  logic [2*W-1:0] a_dr,
  input  logic [2*W-1:0] b_dr,
  input  logic [1:0]     cin_dr,
  input  logic [1:0]     sub_dr,
  output logic           in_ack,
  output logic [2*W-1:0] sum_dr,
  output logic [1:0]     cout_dr,
  input  logic           out_ack,
  output logic           err
);

  localparam int G  = W / DPC;
  localparam int CW = (G > 1) ? $clog2(G) : 1;
  localparam int ND = W + W + 2;   // digits across all inputs

  typedef enum logic [1:0] {IDLE, CALC, HOLD, FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;             // already conditionally inverted
  logic            carry;
  logic [W-1:0]    sum_q;           // partially resolved sum

  logic [2*ND-1:0] all_dr;
  logic            complete;
  logic            empty;
  logic            illegal;
  logic [W-1:0]    a_bin;
  logic [W-1:0]    b_bin;
  logic            sub_bit;
  logic            cin_bit;

  int unsigned     base;
  logic [DPC:0]    grp_sum;
  logic [W-1:0]    sum_next;

  function automatic logic [2*W-1:0] to_dr(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  // Completion detection over every input digit.
  always_comb begin
    all_dr   = {sub_dr, cin_dr, b_dr, a_dr};
    complete = 1'b1;
    empty    = 1'b1;
    illegal  = 1'b0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (all_dr[2*i+1] == all_dr[2*i]) complete = 1'b0;
      if (all_dr[2*i+1] | all_dr[2*i])  empty    = 1'b0;
      if (all_dr[2*i+1] & all_dr[2*i])  illegal  = 1'b1;
    end
    a_bin = '0;
    b_bin = '0;
    for (int unsigned i = 0; i < W; i++) begin
      a_bin[i] = a_dr[2*i+1];
      b_bin[i] = b_dr[2*i+1];
    end
    sub_bit = sub_dr[1];
    cin_bit = cin_dr[1];
  end

  // One digit group per clock; carry ripples between groups through 'carry'.
  always_comb begin
    base     = int'(cnt) * DPC;
    grp_sum  = {1'b0, a_q[base +: DPC]} + {1'b0, b_q[base +: DPC]}
             + {{DPC{1'b0}}, carry};
    sum_next = sum_q;
    sum_next[base +: DPC] = grp_sum[DPC-1:0];
  end

  always_ff @(posedge clk or negedge initN) begin
    if (!initN) begin
      state   <= IDLE;
      cnt     <= '0;
      in_ack  <= 1'b0;
      err     <= 1'b0;
      sum_dr  <= '0;
      cout_dr <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
    end else begin
      if (state != IDLE && empty) in_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (illegal) begin
            err <= 1'b1;
          end else if (complete && !in_ack && !out_ack && !err) begin
            a_q    <= a_bin;
            b_q    <= sub_bit ? ~b_bin : b_bin;
            carry  <= cin_bit ^ sub_bit;
            cnt    <= '0;
            sum_q  <= '0;
            in_ack <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          sum_q <= sum_next;
          carry <= grp_sum[DPC];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(G - 1)) begin
            state   <= HOLD;
            sum_dr  <= to_dr(sum_next);
            cout_dr <= {grp_sum[DPC], ~grp_sum[DPC]};
          end
        end
        HOLD: begin
          if (out_ack) begin
            state   <= FLUSH;
            sum_dr  <= '0;
            cout_dr <= '0;
          end
        end
        FLUSH: begin
          if (!out_ack && !in_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncl_addn_clk.sv
module tb_ncl_addn_clk;
  localparam int W   = 8;
  localparam int DPC = 4;
  localparam int G   = W / DPC;

  logic           clk = 1'b0;
  logic           initN;
  logic [2*W-1:0] a_dr, b_dr, sum_dr;
  logic [1:0]     cin_dr, sub_dr, cout_dr;
  logic           in_ack, out_ack, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];   // {cout, sum}
  logic [W:0] last_exp;

  always #5 clk = ~clk;

  ncl_addn_clk #(.W(W), .DPC(DPC)) dut (
    .clk(clk), .initN(initN), .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
    .sub_dr(sub_dr), .in_ack(in_ack), .sum_dr(sum_dr), .cout_dr(cout_dr),
    .out_ack(out_ack), .err(err)
  );

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] dec(input logic [2*W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[2*i+1];
    return r;
  endfunction

  // Reference: sum = A + (sub ? ~B : B) + (cin ^ sub), cout = bit W.
  function automatic logic [W:0] model(input int unsigned a, input int unsigned b,
                                       input int unsigned cin, input int unsigned sub);
    int unsigned beff, full;
    beff = sub ? ((1 << W) - 1 - b) : b;
    full = a + beff + (cin ^ sub);
    return full[W:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    a_dr   = enc(a);
    b_dr   = enc(b);
    cin_dr = {cin, ~cin};
    sub_dr = {sub, ~sub};
    last_exp = model(a, b, cin, sub);
    exp_q.push_back(last_exp);
  endtask

  task automatic wait_out();
    int n = 0;
    while (cout_dr == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("out_wait", {31'b0, cout_dr != 2'b00}, 1);
  endtask

  // Hold a few cycles, then NULL the inputs and acknowledge the result.
  task automatic tail();
    int k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("hold_sum", dec(sum_dr), last_exp[W-1:0]);
    end
    a_dr = '0; b_dr = '0; cin_dr = '0; sub_dr = '0;
    out_ack = 1'b1;
    @(negedge clk);
    chk("flush_sum_null", sum_dr, 0);
    chk("flush_cout_null", cout_dr, 0);
    chk("in_ack_clear", in_ack, 0);
    out_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic cin, input logic sub);
    @(negedge clk);
    drive(a, b, cin, sub);
    @(negedge clk);
    chk("capture_ack", in_ack, 1);
    wait_out();
    tail();
  endtask

  // Monitor: pops the scoreboard whenever a new DATA result appears.
  initial begin : monitor
    logic prev_ack;
    bit   prev_data;
    bit   data, bad_code;
    int   lat;
    logic [W:0] e;
    prev_ack = 1'b0; prev_data = 1'b0; lat = 1000;
    forever begin
      @(negedge clk);
      if (!initN) begin
        prev_ack = 1'b0; prev_data = 1'b0; lat = 1000;
      end else begin
        if (in_ack && !prev_ack) lat = 0;
        else if (lat < 1000) lat++;
        data = (cout_dr[1] ^ cout_dr[0]);
        bad_code = (cout_dr == 2'b11);
        for (int i = 0; i < W; i++) begin
          if (sum_dr[2*i+1] == sum_dr[2*i]) data = 1'b0;
          if (sum_dr[2*i+1] & sum_dr[2*i]) bad_code = 1'b1;
        end
        chk("out_code_legal", {31'b0, bad_code}, 0);
        if (data && !prev_data) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("sum", dec(sum_dr), e[W-1:0]);
            chk("cout", cout_dr[1], e[W]);
            chk("latency", lat, G);
          end
        end
        prev_data = data;
        prev_ack  = in_ack;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    a_dr = '0; b_dr = '0; cin_dr = '0; sub_dr = '0; out_ack = 1'b0;
    initN = 1'b1;
    #2 initN = 1'b0;
    #1;
    chk("rst_in_ack", in_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_sum", sum_dr, 0);
    chk("rst_cout", cout_dr, 0);
    repeat (2) @(negedge clk);
    initN = 1'b1;

    txn(8'h5A, 8'h33, 1'b0, 1'b0);
    txn(8'hFF, 8'h01, 1'b1, 1'b0);
    txn(8'h10, 8'h20, 1'b0, 1'b1);
    txn(8'h20, 8'h10, 1'b0, 1'b1);

    // Partial DATA must not capture.
    @(negedge clk);
    a_dr = enc(8'h3C);
    repeat (3) begin
      @(negedge clk);
      chk("partial_no_capture", in_ack, 0);
    end
    a_dr = '0;

    // Complete inputs while out_ack held high.
    @(negedge clk);
    out_ack = 1'b1;
    drive(8'hC3, 8'h7E, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("out_ack_blocks", in_ack, 0);
    end
    out_ack = 1'b0;
    @(negedge clk);
    chk("capture_after_ack_drop", in_ack, 1);
    wait_out();
    tail();

    // Illegal code sets sticky err and blocks capture.
    @(negedge clk);
    a_dr = enc(8'h11); b_dr = enc(8'h22); cin_dr = 2'b01; sub_dr = 2'b01;
    b_dr[7:6] = 2'b11;
    @(negedge clk);
    chk("err_set", err, 1);
    drive(8'h9C, 8'h47, 1'b0, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("err_blocks", in_ack, 0);
    end
    chk("err_sticky", err, 1);
    initN = 1'b0;
    #1;
    chk("err_cleared", err, 0);
    @(negedge clk);
    initN = 1'b1;
    @(negedge clk);
    chk("recapture_after_err", in_ack, 1);
    wait_out();
    tail();

    // Reset one cycle after capture aborts, then recaptures.
    @(negedge clk);
    drive(8'hA5, 8'h6B, 1'b1, 1'b1);
    @(negedge clk);
    chk("capture_before_abort", in_ack, 1);
    initN = 1'b0;
    #1;
    chk("abort_in_ack", in_ack, 0);
    chk("abort_sum", sum_dr, 0);
    chk("abort_cout", cout_dr, 0);
    @(negedge clk);
    initN = 1'b1;
    @(negedge clk);
    chk("recapture_after_abort", in_ack, 1);
    wait_out();
    tail();

    for (int t = 0; t < 40; t++) begin
      txn(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
